// File: rtl/pool_max_stream_pkg.sv
// Shared types for the streaming max-pool block: pixel width, lane vector and FSM states.
package pool_max_stream_pkg;

    localparam int DWIDTH     = 16;
    localparam int N_LANE_DEF = 8;

    typedef logic signed [DWIDTH-1:0] pix_t;
    typedef pix_t [N_LANE_DEF-1:0]    lane_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/pool_max_stream_if.sv
// Control, pixel-in and result handshake bundle for pool_max_stream.
interface pool_max_stream_if #(
    parameter int N_LANE    = 8,
    parameter int PSIZE_MAX = 4
);
    import pool_max_stream_pkg::*;

    localparam int PSW = $clog2(PSIZE_MAX + 1);

    logic                  start;
    logic [PSW-1:0]        pool_size;
    logic                  relu_en;
    logic                  in_valid;
    logic                  in_ready;
    pix_t [N_LANE-1:0]     pixel_in;
    logic                  out_valid;
    logic                  out_ready;
    pix_t [N_LANE-1:0]     pixel_out;
    logic                  busy;

    modport master (
        output start, pool_size, relu_en, in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, pixel_out, busy
    );

    modport slave (
        input  start, pool_size, relu_en, in_valid, pixel_in, out_ready,
        output in_ready, out_valid, pixel_out, busy
    );

endinterface

// File: rtl/pool_max_stream_lane.sv
// One channel of the max-pool: running signed max over the window, ReLU applied when the result is latched.
module pool_max_lane
    import pool_max_stream_pkg::*;
(
    input  logic clk,
    input  logic xrst,
    input  logic en,
    input  logic first,
    input  logic last,
    input  logic relu_en,
    input  pix_t pixel_in,
    output pix_t pixel_out
);

    function automatic pix_t max_s(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t relu_floor(input pix_t v, input logic floor_en);
        return (floor_en && (v < 0)) ? '0 : v;
    endfunction

    pix_t acc_p0;
    pix_t acc_nxt;

    // First beat overwrites, so the most-negative value survives without a zero bias.
    always_comb begin
        acc_nxt = first ? pixel_in : max_s(acc_p0, pixel_in);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            acc_p0    <= '0;
            pixel_out <= '0;
        end else begin
            if (en) begin
                acc_p0 <= acc_nxt;
            end
            if (en && last) begin
                pixel_out <= relu_floor(acc_nxt, relu_en);
            end
        end
    end

endmodule

// File: rtl/pool_max_stream.sv
// Streaming KxK max-pool over N_LANE channels: window FSM, beat counter and result handshake.
module pool_max_stream
    import pool_max_stream_pkg::*;
#(
    parameter int N_LANE    = 8,
    parameter int PSIZE_MAX = 4
) (
    input  logic               clk,
    input  logic               xrst,
    pool_max_stream_if.slave   bus
);

    localparam int PSW = $clog2(PSIZE_MAX + 1);
    localparam int CW  = $clog2(PSIZE_MAX * PSIZE_MAX + 1);

    // K=0 behaves as 1 and oversize K saturates at the largest supported window.
    function automatic logic [CW-1:0] win_target(input logic [PSW-1:0] ps);
        int k;
        k = int'(ps);
        if (k < 1) k = 1;
        if (k > PSIZE_MAX) k = PSIZE_MAX;
        return CW'(k * k);
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   target_q;
    logic            relu_q;
    logic            accept;
    logic            open_win;
    logic            last_beat;
    logic            first_beat;
    logic            in_ready_c;
    logic            out_valid_c;
    pix_t [N_LANE-1:0] lane_out;

    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == (target_q - CW'(1)));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        open_win    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    open_win = 1'b1;
                    state_d  = ACC;
                end
            end
            ACC: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
                if (accept && last_beat) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    if (bus.start) begin
                        open_win = 1'b1;
                        state_d  = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            cnt_q    <= '0;
            target_q <= CW'(1);
            relu_q   <= 1'b0;
        end else if (open_win) begin
            cnt_q    <= '0;
            target_q <= win_target(bus.pool_size);
            relu_q   <= bus.relu_en;
        end else if (accept) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    for (genvar i = 0; i < N_LANE; i++) begin : g_lane
        pool_max_lane u_lane (
            .clk       (clk),
            .xrst      (xrst),
            .en        (accept),
            .first     (first_beat),
            .last      (last_beat),
            .relu_en   (relu_q),
            .pixel_in  (bus.pixel_in[i]),
            .pixel_out (lane_out[i])
        );
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.pixel_out = lane_out;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pool_max_stream.sv
// Directed bench for pool_max_stream: windows of several sizes, ReLU, gaps, back-pressure, back-to-back and reset.
module tb_pool_max_stream;
    import pool_max_stream_pkg::*;

    localparam int NL = 8;
    localparam int PM = 4;

    logic clk  = 1'b0;
    logic xrst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    pool_max_stream_if #(.N_LANE(NL), .PSIZE_MAX(PM)) bus ();

    pool_max_stream #(.N_LANE(NL), .PSIZE_MAX(PM)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_win(input int k, input logic relu);
        bus.start     = 1'b1;
        bus.pool_size = 3'(k);
        bus.relu_en   = relu;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic beat(input lane_vec_t v);
        bus.in_valid = 1'b1;
        bus.pixel_in = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        n_vec++; if (bus.pixel_out !== '0) begin n_bad++; $display("FAIL rst_pixel_out got %h exp 0", bus.pixel_out); end
    endtask

    task automatic test_k2_basic();
        lane_vec_t v, exp_v;
        int b0 [4] = '{3, -5, 7, 1};
        open_win(2, 1'b0);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL k2_in_ready got %b exp 1", bus.in_ready); end
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NL; i++) begin
                case (b)
                    0: v[i] = pix_t'(i);
                    1: v[i] = pix_t'(-i);
                    2: v[i] = pix_t'(2 * i);
                    default: v[i] = '0;
                endcase
            end
            v[0] = pix_t'(b0[b]);
            if (b == 3) begin
                n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL k2_early_valid got %b exp 0", bus.out_valid); end
            end
            beat(v);
        end
        for (int i = 0; i < NL; i++) exp_v[i] = pix_t'(2 * i);
        exp_v[0] = pix_t'(7);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL k2_out_valid got %b exp 1", bus.out_valid); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL k2_data got %h exp %h", bus.pixel_out, exp_v); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL k2_in_ready_out got %b exp 0", bus.in_ready); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL k2_hold_valid got %b exp 1", bus.out_valid); end
        ack();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL k2_valid_drop got %b exp 0", bus.out_valid); end
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL k2_idle_busy got %b exp 0", bus.busy); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL k2_data_hold got %h exp %h", bus.pixel_out, exp_v); end
    endtask

    task automatic test_k3_neg(input logic relu);
        lane_vec_t v, exp_v;
        open_win(3, relu);
        for (int b = 0; b < 9; b++) begin
            for (int i = 0; i < NL; i++) v[i] = pix_t'(-9 + b - i);
            beat(v);
        end
        for (int i = 0; i < NL; i++) exp_v[i] = relu ? pix_t'(0) : pix_t'(-1 - i);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL k3_valid relu=%b got %b exp 1", relu, bus.out_valid); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL k3_data relu=%b got %h exp %h", relu, bus.pixel_out, exp_v); end
        ack();
    endtask

    task automatic test_most_negative();
        lane_vec_t v, exp_v;
        pix_t minv;
        minv = {1'b1, {(DWIDTH-1){1'b0}}};
        for (int i = 0; i < NL; i++) v[i] = minv;
        exp_v = v;
        open_win(2, 1'b0);
        for (int b = 0; b < 4; b++) beat(v);
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL minval_data got %h exp %h", bus.pixel_out, exp_v); end
        ack();
    endtask

    task automatic test_gaps_backpressure();
        lane_vec_t v, exp_v, junk;
        int b0 [4] = '{10, -3, 25, 4};
        open_win(2, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NL; i++) v[i] = pix_t'(b0[b] + i);
            beat(v);
            if (b < 3) begin
                tick();
                tick();
            end
        end
        for (int i = 0; i < NL; i++) begin
            exp_v[i] = pix_t'(25 + i);
            junk[i]  = pix_t'(1000);
        end
        bus.in_valid = 1'b1;
        bus.pixel_in = junk;
        bus.start    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL gap_valid c=%0d got %b exp 1", c, bus.out_valid); end
            n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL gap_data c=%0d got %h exp %h", c, bus.pixel_out, exp_v); end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        ack();
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL gap_idle got %b exp 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        lane_vec_t v, exp_v;
        open_win(2, 1'b0);
        for (int i = 0; i < NL; i++) v[i] = pix_t'(5);
        for (int b = 0; b < 4; b++) beat(v);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.pool_size = 3'd1;
        bus.relu_en   = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_out_valid got %b exp 0", bus.out_valid); end
        for (int i = 0; i < NL; i++) v[i] = pix_t'(42 - i);
        exp_v = v;
        beat(v);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid2 got %b exp 1", bus.out_valid); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL b2b_data got %h exp %h", bus.pixel_out, exp_v); end
        ack();
    endtask

    task automatic test_clamp();
        lane_vec_t v, exp_v;
        open_win(0, 1'b1);
        for (int i = 0; i < NL; i++) v[i] = pix_t'(i - 3);
        beat(v);
        for (int i = 0; i < NL; i++) exp_v[i] = (i < 3) ? pix_t'(0) : pix_t'(i - 3);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL k0_valid got %b exp 1", bus.out_valid); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL k0_relu_data got %h exp %h", bus.pixel_out, exp_v); end
        ack();
        open_win(7, 1'b0);
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < NL; i++) v[i] = pix_t'(-b - i);
            v[0] = pix_t'(b);
            if (b == 15) begin
                n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL k7_early_valid got %b exp 0", bus.out_valid); end
                n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL k7_in_ready got %b exp 1", bus.in_ready); end
            end
            beat(v);
        end
        for (int i = 0; i < NL; i++) exp_v[i] = pix_t'(-i);
        exp_v[0] = pix_t'(15);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL k7_valid got %b exp 1", bus.out_valid); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL k7_data got %h exp %h", bus.pixel_out, exp_v); end
        ack();
    endtask

    task automatic test_reset_mid();
        lane_vec_t v, exp_v;
        open_win(2, 1'b0);
        for (int i = 0; i < NL; i++) v[i] = pix_t'(500);
        beat(v);
        beat(v);
        #1 xrst = 1'b0;
        #2;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_in_ready got %b exp 0", bus.in_ready); end
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b exp 0", bus.busy); end
        n_vec++; if (bus.pixel_out !== '0) begin n_bad++; $display("FAIL mid_rst_pixel got %h exp 0", bus.pixel_out); end
        #2 xrst = 1'b1;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
        open_win(2, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NL; i++) v[i] = pix_t'(-(b + 1) - 2 * i);
            beat(v);
        end
        for (int i = 0; i < NL; i++) exp_v[i] = pix_t'(-1 - 2 * i);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL post_rst_valid got %b exp 1", bus.out_valid); end
        n_vec++; if (bus.pixel_out !== exp_v) begin n_bad++; $display("FAIL post_rst_data got %h exp %h", bus.pixel_out, exp_v); end
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.pool_size = '0;
        bus.relu_en   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.pixel_in  = '0;
        bus.out_ready = 1'b0;
        #22;
        test_reset();
        tick();
        xrst = 1'b1;
        tick();
        test_k2_basic();
        test_k3_neg(1'b0);
        test_k3_neg(1'b1);
        test_most_negative();
        test_gaps_backpressure();
        test_back_to_back();
        test_clamp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
